pixel_stream_out: RTL
=====================

Name: pixel_stream_out

Overview:
- Downstream stage of the pixel memory handler. Each read strobe delivers one pixel pair (bus 1, bus 2) and a one-hot row select.
- The block buffers pairs in a small FIFO. It serialises them into a single 8-bit pixel stream with a valid/ready handshake and start-of-frame, end-of-line and end-of-frame markers.
- It decouples array readout timing from the off-chip output interface and flags overflow and malformed row selects.

Parameters:
- DEPTH, 4, FIFO depth in pixel-pair entries; power of two, at least 2.
- ROWS, 4, rows per frame; equals the width of in_sel.

Ports:
- clk  input  1  clock.
- frame_reset  input  1  asynchronous, active-high reset; also marks frame boundary.
- in_valid  input  1  pair on in_pix1/in_pix2 is valid this cycle (read strobe delayed one cycle, aligned with registered pixel data).
- in_pix1  input  8  pixel from data bus 1 (first column).
- in_pix2  input  8  pixel from data bus 2 (second column).
- in_sel  input  ROWS  one-hot row select associated with the pair.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data holds a valid pixel.
- out_data  output  8  serialised pixel.
- out_sof  output  1  out_data is the first pixel of the frame.
- out_eol  output  1  out_data is the last pixel of a row.
- out_eof  output  1  out_data is the last pixel of the frame.
- overflow  output  1  sticky: a pair was dropped because the FIFO was full.
- sel_err  output  1  sticky: in_valid seen with in_sel not one-hot.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy in pairs.

Behaviour:
- Reset (asynchronous, frame_reset high):
  - FIFO is emptied.
  - FSM goes to EMPTY.
  - out_valid, out_data, out_sof, out_eol, out_eof, overflow, sel_err, level are all 0.
  - Reset mid-stream discards all buffered and in-flight pixels; no partial pair is emitted afterwards.
- Write side:
  - On a rising edge with in_valid=1, if level<DEPTH, the entry {in_pix1, in_pix2, sof=in_sel[0], eof=in_sel[ROWS-1]} is pushed.
  - Full is evaluated from level at the start of the cycle. A push while level==DEPTH is dropped and sets overflow, even if a pop occurs in the same cycle.
  - If in_sel is not one-hot while in_valid=1, sel_err is set. The pair is still pushed, with sof and eof taken bitwise as above.
  - Sticky flags clear only on frame_reset.
- Output FSM has three states, EMPTY, PIX1 and PIX2, with registered outputs.
  - EMPTY: out_valid=0. If level>0, pop the head at the edge and load the output register with pix1, sof, eol=0, eof=0. Next state is PIX1. The popped pix2, sof and eof are held in a side register.
  - PIX1: out_valid=1. On out_ready, load pix2 with sof=0, eol=1, eof=held eof. Next state is PIX2.
  - PIX2: out_valid=1. On out_ready:
    - if level>0, pop and load the next pix1 (go to PIX1), giving back-to-back streaming with no bubble;
    - otherwise go to EMPTY with out_valid=0.
  - While out_valid=1 and out_ready=0, out_data and all marker outputs hold stable.
- Latency: a pair sampled at edge E0 with the FIFO and FSM empty gives out_valid=1 with pix1 after edge E1, and pix2 after the first subsequent edge with out_ready=1.
- Throughput: 1 pixel/cycle at out_ready=1. Input must average at most 1 pair per 2 cycles to avoid overflow.
- Simultaneous push and pop: both take effect and level is unchanged.
- level counts pairs in the FIFO only, excluding the pair held in the output register.

Decomposition:
- Package pix_pkg holds:
  - PIX_W=8;
  - typedef pair_t {pix1, pix2, sof, eof};
  - enum out_state_t {EMPTY, PIX1, PIX2}.
- Sub-module pix_pair_fifo: synchronous pair_t FIFO, DEPTH parameter, async frame_reset, push/pop/full/empty/level. Drop-on-full policy lives in the parent.

Test Plan:
- Reset, then 4 strobes (in_sel 0001,0010,0100,1000; pixels 10/11,20/21,30/31,40/41) with out_ready=1 -> stream 10,11,20,21,30,31,40,41 with no gaps. out_sof on 10; out_eol on 11,21,31,41; out_eof on 41; level returns to 0.
- out_ready=0 for 5 cycles while out_valid=1 with pixel 0xAA -> out_data=0xAA and markers stable throughout; stream resumes in order.
- out_ready=0, push 5 pairs (DEPTH=4) -> 1st pair in the output register, next 4 buffered; no overflow, level=4. A 6th push -> overflow=1, level stays 4, that pair never appears.
- in_valid with in_sel=0110 -> sel_err=1 sticky; pair still emitted with sof=0, eof=0.
- frame_reset asserted mid-frame with level=3 and out_valid=1 -> next cycle all outputs 0 and flags cleared; the next strobe with in_sel=0001 yields out_sof on its first pixel.
- Push and pop in the same cycle at level=2 -> level stays 2, order preserved.

Source files
------------

// File: rtl/pixel_stream_out_pkg.sv
// Shared types for the pixel output stage: pair entry layout and the
// serialiser states.
package pix_pkg;

   localparam int PIX_W = 8;

   typedef struct packed {
      logic [PIX_W-1:0] pix1;
      logic [PIX_W-1:0] pix2;
      logic             sof;
      logic             eof;
   } pair_t;

   typedef enum logic [1:0] {
      EMPTY,
      PIX1,
      PIX2
   } out_state_t;

endpackage

// File: rtl/pixel_stream_out_if.sv
// Pixel-pair input strobe and serialised pixel output handshake.
interface pixel_stream_out_if #(
   parameter int ROWS = 4
) ();
   import pix_pkg::*;

   logic             in_valid;
   logic [PIX_W-1:0] in_pix1;
   logic [PIX_W-1:0] in_pix2;
   logic [ROWS-1:0]  in_sel;
   logic             out_ready;
   logic             out_valid;
   logic [PIX_W-1:0] out_data;
   logic             out_sof;
   logic             out_eol;
   logic             out_eof;

   modport master (
      output in_valid, in_pix1, in_pix2, in_sel, out_ready,
      input  out_valid, out_data, out_sof, out_eol, out_eof
   );

   modport slave (
      input  in_valid, in_pix1, in_pix2, in_sel, out_ready,
      output out_valid, out_data, out_sof, out_eol, out_eof
   );

endinterface

// File: rtl/pixel_stream_out_fifo.sv
// Synchronous pair FIFO; the caller guarantees no push when full and no pop
// when empty.
module pix_pair_fifo
   import pix_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     frame_reset,
   input  logic                     push_i,
   input  pair_t                    wr_data_i,
   input  logic                     pop_i,
   output pair_t                    rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   pair_t            mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    count_q;

   // NOTE: storage has no reset; the pointers and count alone define which
   // entries are meaningful, so clearing the array would only cost area.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge frame_reset) begin
      if (frame_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign full_o    = (count_q == LW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign level_o   = count_q;

endmodule

// File: rtl/pixel_stream_out.sv
// Buffers pixel pairs from the memory handler and serialises them into one
// 8-bit stream with SOF/EOL/EOF markers and sticky error flags.
module pixel_stream_out
   import pix_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ROWS  = 4
) (
   input  logic                   clk,
   input  logic                   frame_reset,
   pixel_stream_out_if.slave      bus,
   output logic                   overflow,
   output logic                   sel_err,
   output logic [$clog2(DEPTH):0] level
);

   pair_t            wr_pair;
   pair_t            head;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             load_head;

   out_state_t       state_q, state_d;
   logic [PIX_W-1:0] data_q, data_d;
   logic             sof_q, sof_d;
   logic             eol_q, eol_d;
   logic             eof_q, eof_d;
   logic [PIX_W-1:0] hold_pix2_q, hold_pix2_d;
   logic             hold_eof_q, hold_eof_d;
   logic             overflow_q;
   logic             sel_err_q;

   // Full is judged on the occupancy at the start of the cycle, so a pop in
   // the same cycle never rescues a push into a full FIFO.
   assign push    = bus.in_valid && !fifo_full;
   assign wr_pair = '{pix1: bus.in_pix1, pix2: bus.in_pix2,
                      sof:  bus.in_sel[0], eof: bus.in_sel[ROWS-1]};

   pix_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .frame_reset(frame_reset),
      .push_i     (push),
      .wr_data_i  (wr_pair),
      .pop_i      (pop),
      .rd_data_o  (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (level)
   );

   always_ff @(posedge clk or posedge frame_reset) begin
      if (frame_reset) begin
         overflow_q <= 1'b0;
         sel_err_q  <= 1'b0;
      end else begin
         if (bus.in_valid && fifo_full)           overflow_q <= 1'b1;
         if (bus.in_valid && !$onehot(bus.in_sel)) sel_err_q  <= 1'b1;
      end
   end

   // NOTE: every next-state signal gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      sof_d       = sof_q;
      eol_d       = eol_q;
      eof_d       = eof_q;
      hold_pix2_d = hold_pix2_q;
      hold_eof_d  = hold_eof_q;
      load_head   = 1'b0;
      pop         = 1'b0;

      case (state_q)
         EMPTY: load_head = !fifo_empty;
         PIX1: begin
            if (bus.out_ready) begin
               data_d  = hold_pix2_q;
               sof_d   = 1'b0;
               eol_d   = 1'b1;
               eof_d   = hold_eof_q;
               state_d = PIX2;
            end
         end
         PIX2: begin
            if (bus.out_ready) begin
               if (!fifo_empty) begin
                  load_head = 1'b1;
               end else begin
                  data_d  = '0;
                  sof_d   = 1'b0;
                  eol_d   = 1'b0;
                  eof_d   = 1'b0;
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      if (load_head) begin
         pop         = 1'b1;
         data_d      = head.pix1;
         sof_d       = head.sof;
         eol_d       = 1'b0;
         eof_d       = 1'b0;
         hold_pix2_d = head.pix2;
         hold_eof_d  = head.eof;
         state_d     = PIX1;
      end
   end

   always_ff @(posedge clk or posedge frame_reset) begin
      if (frame_reset) begin
         state_q     <= EMPTY;
         data_q      <= '0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         hold_pix2_q <= '0;
         hold_eof_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         sof_q       <= sof_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
         hold_pix2_q <= hold_pix2_d;
         hold_eof_q  <= hold_eof_d;
      end
   end

   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_data  = data_q;
   assign bus.out_sof   = sof_q;
   assign bus.out_eol   = eol_q;
   assign bus.out_eof   = eof_q;
   assign overflow      = overflow_q;
   assign sel_err       = sel_err_q;

endmodule
